// File: rtl/dp_arbiter.sv
// dp_arbiter: round-robin arbiter sharing one start/finished datapath among N_REQ requesters.
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif
`ifndef RESULT_WIDTH
`define RESULT_WIDTH 32
`endif
module dp_arbiter #(
    parameter int N_REQ   = 4,
    parameter int GRANT_W = 2
) (
    input  logic                                clock,
    input  logic                                resetn,
    input  logic [N_REQ-1:0]                    req_start,
    input  logic [N_REQ*`INSTRUCTION_WIDTH-1:0] req_instruction,
    output logic [N_REQ-1:0]                    req_finished,
    output logic [`RESULT_WIDTH-1:0]            req_result,
    output logic                                start_dp,
    output logic [`INSTRUCTION_WIDTH-1:0]       instruction_dp,
    input  logic                                finished_dp,
    input  logic [`RESULT_WIDTH-1:0]            result_dp,
    output logic [GRANT_W-1:0]                  grant,
    output logic                                busy
);
    localparam int IW = `INSTRUCTION_WIDTH;
    localparam int RW = `RESULT_WIDTH;

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD, WAIT} state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   pending_q, pending_d, finished_q, finished_d, capture, in_service;
    logic [IW-1:0]      instr_q [N_REQ];
    logic [IW-1:0]      instr_d [N_REQ];
    logic [IW-1:0]      instruction_dp_q, instruction_dp_d;
    logic [RW-1:0]      result_q, result_d;
    logic [GRANT_W-1:0] grant_q, grant_d, rr_ptr_q, rr_ptr_d, sel, idx;
    logic               found;

    assign busy       = state_q != IDLE;
    assign in_service = busy ? (N_REQ'(1) << grant_q) : '0;
    assign capture    = req_start & ~pending_q & ~in_service & finished_q;

    // First pending index at or after rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = GRANT_W'((int'(rr_ptr_q) + k) % N_REQ);
            if (!found && pending_q[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        pending_d        = pending_q | capture;
        finished_d       = finished_q & ~capture;
        instruction_dp_d = instruction_dp_q;
        result_d         = result_q;
        grant_d          = grant_q;
        rr_ptr_d         = rr_ptr_q;
        for (int i = 0; i < N_REQ; i++)
            instr_d[i] = capture[i] ? req_instruction[i*IW +: IW] : instr_q[i];
        case (state_q)
            IDLE: if (found) begin
                state_d          = ISSUE;
                grant_d          = sel;
                pending_d[sel]   = 1'b0;
                instruction_dp_d = instr_q[sel];
            end
            ISSUE: state_d = HOLD;
            HOLD:  state_d = WAIT;
            WAIT: if (finished_dp) begin
                state_d             = IDLE;
                result_d            = result_dp;
                finished_d[grant_q] = 1'b1;
                rr_ptr_d            = (grant_q == GRANT_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q          <= IDLE;
            pending_q        <= '0;
            finished_q       <= '1;
            instr_q          <= '{default: '0};
            instruction_dp_q <= '0;
            result_q         <= '0;
            grant_q          <= '0;
            rr_ptr_q         <= '0;
        end else begin
            state_q          <= state_d;
            pending_q        <= pending_d;
            finished_q       <= finished_d;
            instr_q          <= instr_d;
            instruction_dp_q <= instruction_dp_d;
            result_q         <= result_d;
            grant_q          <= grant_d;
            rr_ptr_q         <= rr_ptr_d;
        end
    end

    assign req_finished   = finished_q;
    assign req_result     = result_q;
    assign start_dp       = (state_q == ISSUE) || (state_q == HOLD);
    assign instruction_dp = instruction_dp_q;
    assign grant          = grant_q;
endmodule

// File: tb/tb_dp_arbiter.sv
// tb_dp_arbiter: directed bench for dp_arbiter with a small datapath model and issue monitor.
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif
`ifndef RESULT_WIDTH
`define RESULT_WIDTH 32
`endif
module tb_dp_arbiter;
    logic         clock = 1'b0;
    logic         resetn;
    logic [3:0]   req_start;
    logic [127:0] req_instruction;
    logic [3:0]   req_finished;
    logic [31:0]  req_result;
    logic         start_dp;
    logic [31:0]  instruction_dp;
    logic         finished_dp;
    logic [31:0]  result_dp;
    logic [1:0]   grant;
    logic         busy;

    int checks = 0;
    int failures = 0;
    int dp_lat = 3;
    int unstable = 0;
    logic [1:0]  grants[$];
    logic [31:0] instrs[$];
    int          lens[$];

    dp_arbiter dut (
        .clock(clock), .resetn(resetn), .req_start(req_start),
        .req_instruction(req_instruction), .req_finished(req_finished),
        .req_result(req_result), .start_dp(start_dp), .instruction_dp(instruction_dp),
        .finished_dp(finished_dp), .result_dp(result_dp), .grant(grant), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic set_instr(input int i, input logic [31:0] v);
        req_instruction[i*32 +: 32] = v;
    endtask

    task automatic wait_fin(input int i, input int maxc);
        int n = 0;
        while (req_finished[i] !== 1'b1 && n < maxc) begin
            tick(1);
            n++;
        end
        if (n >= maxc) check("timeout_fin", 64'(i), 64'hFF);
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while (!(req_finished === 4'hF && busy === 1'b0) && n < maxc) begin
            tick(1);
            n++;
        end
        if (n >= maxc) check("timeout_idle", 0, 1);
    endtask

    task automatic clear_log();
        grants.delete();
        instrs.delete();
        lens.delete();
    endtask

    // Datapath: drops finished on start, returns 2*instr[7:0] after dp_lat idle cycles.
    initial begin
        int cnt = 0;
        logic [31:0] ins = '0;
        finished_dp = 1'b1;
        result_dp = '0;
        forever begin
            @(negedge clock);
            if (start_dp === 1'b1) begin
                finished_dp = 1'b0;
                cnt = dp_lat;
                ins = instruction_dp;
            end else if (!finished_dp) begin
                if (cnt == 0) begin
                    finished_dp = 1'b1;
                    result_dp = {23'b0, ins[7:0], 1'b0};
                end else cnt--;
            end
        end
    end

    // Issue monitor: logs grant/instruction per start_dp pulse and pulse length.
    initial begin
        logic prev = 1'b0;
        logic [31:0] cur = '0;
        int run = 0;
        forever begin
            @(negedge clock);
            if (start_dp === 1'b1 && !prev) begin
                grants.push_back(grant);
                instrs.push_back(instruction_dp);
                cur = instruction_dp;
                run = 0;
            end
            if (start_dp === 1'b1) run++;
            if (start_dp !== 1'b1 && prev) lens.push_back(run);
            if (busy === 1'b1 && instruction_dp !== cur) unstable++;
            prev = (start_dp === 1'b1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        resetn = 1'b0;
        req_start = '0;
        req_instruction = '0;
        tick(2);
        check("rst_start_dp", 64'(start_dp), 0);
        check("rst_finished", 64'(req_finished), 64'hF);
        check("rst_busy", 64'(busy), 0);
        check("rst_grant", 64'(grant), 0);
        check("rst_result", 64'(req_result), 0);
        check("rst_instr", 64'(instruction_dp), 0);
        resetn = 1'b1;
        tick(1);

        // Single request on port 1
        clear_log();
        set_instr(1, 32'h3000_0005);
        req_start[1] = 1'b1;
        tick(1);
        check("single_capture_fin", 64'(req_finished), 64'hD);
        check("single_idle_after_capture", 64'(busy), 0);
        tick(1);
        check("single_issue_2cyc", 64'(start_dp), 1);
        req_start[1] = 1'b0;
        wait_idle(60);
        check("single_issues", 64'(grants.size()), 1);
        if (grants.size() == 1) begin
            check("single_instr", 64'(instrs[0]), 64'h3000_0005);
            check("single_pulse", 64'(lens[0]), 2);
        end
        check("single_result", 64'(req_result), 64'h0A);
        check("single_grant", 64'(grant), 1);

        // Contention from rr_ptr=0
        resetn = 1'b0;
        tick(1);
        resetn = 1'b1;
        tick(1);
        clear_log();
        set_instr(0, 32'h0000_0011);
        set_instr(2, 32'h0000_0022);
        set_instr(3, 32'h0000_0033);
        req_start = 4'b1101;
        tick(1);
        req_start = '0;
        check("cont_capture_fin", 64'(req_finished), 64'h2);
        wait_fin(0, 60);
        check("cont_fin_after0", 64'(req_finished), 64'h3);
        check("cont_result0", 64'(req_result), 64'h22);
        wait_fin(2, 60);
        check("cont_fin_after2", 64'(req_finished), 64'h7);
        check("cont_result2", 64'(req_result), 64'h44);
        wait_fin(3, 60);
        check("cont_result3", 64'(req_result), 64'h66);
        check("cont_issues", 64'(grants.size()), 3);
        if (grants.size() == 3 && lens.size() == 3) begin
            check("cont_order", {grants[0], grants[1], grants[2]}, {2'd0, 2'd2, 2'd3});
            check("cont_pulses", {8'(lens[0]), 8'(lens[1]), 8'(lens[2])}, 24'h020202);
        end

        // Fairness: port 0 keeps re-requesting, port 1 requests once
        clear_log();
        req_start = 4'b0011;
        tick(1);
        req_start[1] = 1'b0;
        n = 0;
        while (grants.size() < 3 && n < 200) begin
            tick(1);
            n++;
        end
        req_start[0] = 1'b0;
        wait_idle(60);
        check("fair_issues", 64'(grants.size()), 3);
        if (grants.size() == 3)
            check("fair_order", {grants[0], grants[1], grants[2]}, {2'd0, 2'd1, 2'd0});

        // Late arrival on port 2 while port 0 is in WAIT
        clear_log();
        dp_lat = 6;
        set_instr(0, 32'h0000_0010);
        set_instr(2, 32'h0000_0007);
        req_start[0] = 1'b1;
        tick(1);
        req_start[0] = 1'b0;
        tick(3);
        check("late_in_wait", {busy, start_dp, grant}, {1'b1, 1'b0, 2'd0});
        req_start[2] = 1'b1;
        tick(1);
        req_start[2] = 1'b0;
        check("late_capture_fin", 64'(req_finished[2]), 0);
        wait_fin(0, 60);
        check("late_result0", 64'(req_result), 64'h20);
        check("late_fin2_low", 64'(req_finished[2]), 0);
        n = 0;
        while (!(start_dp === 1'b1 && grant === 2'd2) && n < 60) begin
            tick(1);
            n++;
        end
        check("late_result_held", 64'(req_result), 64'h20);
        wait_fin(2, 60);
        check("late_result2", 64'(req_result), 64'h0E);
        check("late_issues", 64'(grants.size()), 2);
        if (grants.size() == 2) check("late_order", {grants[0], grants[1]}, {2'd0, 2'd2});

        // Held start for 10 cycles yields one transaction
        clear_log();
        dp_lat = 12;
        set_instr(1, 32'h0000_0009);
        req_start[1] = 1'b1;
        tick(10);
        req_start[1] = 1'b0;
        wait_idle(80);
        check("held_issues", 64'(grants.size()), 1);
        check("held_result", 64'(req_result), 64'h12);

        // Reset in WAIT with port 3 pending
        dp_lat = 10;
        set_instr(0, 32'h0000_0040);
        set_instr(3, 32'h0000_0030);
        req_start[0] = 1'b1;
        tick(1);
        req_start[0] = 1'b0;
        tick(3);
        check("rstw_in_wait", {busy, start_dp}, 2'b10);
        req_start[3] = 1'b1;
        tick(1);
        req_start[3] = 1'b0;
        check("rstw_pending_fin", 64'(req_finished), 64'h6);
        resetn = 1'b0;
        tick(1);
        resetn = 1'b1;
        check("rstw_start_dp", 64'(start_dp), 0);
        check("rstw_finished", 64'(req_finished), 64'hF);
        check("rstw_busy", 64'(busy), 0);
        check("rstw_result", 64'(req_result), 0);
        clear_log();
        tick(30);
        check("rstw_no_issue", 64'(grants.size()), 0);
        check("rstw_result_after", 64'(req_result), 0);
        check("instr_stable", 64'(unstable), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
